spi_master: RTL and testbench

- SPI controller (mode 0: CPOL=0, CPHA=0) in the clk domain; generates ssn, sck and mosi, and samples miso.
- Drives the existing SPI slave shifter: the slave shifts miso on sck falling edges and samples mosi on sck rising edges.
- Byte-stream valid/ready on the Tx side; Rx bytes are presented as a 1-cycle pulse.
- One byte holding register lets bursts run with a continuous sck. tx_last closes the transaction.

---
 rtl/spi_master.sv | 197 +++++++++++++++++++
 tb/tb_spi_master.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 master with a one-byte Tx holding register
//
// Purpose: drives ssn/sck/mosi and samples miso (CPOL=0, CPHA=0). A byte held
// in the holding register while the current byte shifts keeps sck continuous
// across bytes; tx_last on a byte closes the transaction after it.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   tx_vld/tx_rdy            Tx byte handshake (accept when both high)
//   tx_dat, tx_last          Tx byte (MSB first) and end-of-transaction flag
//   rx_vld, rx_dat           1-cycle pulse with received byte; rx_dat held
//   busy                     high whenever the controller is not IDLE
//   ssn, sck, mosi           registered SPI outputs
//   miso                     SPI serial input
module spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_vld,
  output logic       tx_rdy,
  input  logic [7:0] tx_dat,
  input  logic       tx_last,
  output logic       rx_vld,
  output logic [7:0] rx_dat,
  output logic       busy,
  output logic       ssn,
  output logic       sck,
  output logic       mosi,
  input  logic       miso
);

  localparam int HW     = $clog2(CLK_DIV);
  localparam int CS_M1  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CS_MAX = (CS_M1 > CS_IDLE) ? CS_M1 : CS_IDLE;
  localparam int CW     = $clog2(CS_MAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, WAIT, HOLD, GAP} state_t;
  state_t state, state_nxt;

  logic [HW-1:0] half_cnt;
  logic [2:0]    bit_cnt;
  logic [CW-1:0] cs_cnt;
  logic [CW-1:0] cs_lim;
  // tx_sr holds the bits still to go after the one on mosi; rx_sr holds the
  // seven bits already received, so the byte completes as {rx_sr, miso}.
  logic [6:0]    tx_sr;
  logic [6:0]    rx_sr;
  logic [7:0]    hold_dat;
  logic          hold_last, hold_full, cur_last;
  logic          accept, half_end, sck_rise, sck_fall, byte_end, cs_end;

  assign accept   = tx_vld & tx_rdy;
  assign half_end = (half_cnt == HW'(CLK_DIV - 1));
  assign sck_rise = (state == XFER) & ~sck & half_end;
  assign sck_fall = (state == XFER) & sck & half_end;
  assign byte_end = sck_fall & (bit_cnt == 3'd7);
  assign cs_end   = (cs_cnt == cs_lim);

  always_comb begin
    cs_lim = CW'(CS_IDLE - 1);
    case (state)
      SETUP:   cs_lim = CW'(CS_SETUP - 1);
      HOLD:    cs_lim = CW'(CS_HOLD - 1);
      default: cs_lim = CW'(CS_IDLE - 1);
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = SETUP;
      SETUP: if (cs_end) state_nxt = XFER;
      XFER: begin
        // A byte accepted on the byte-end edge itself (hold empty) is loaded
        // straight into the shifter, so it also keeps XFER running.
        if (byte_end) begin
          if (cur_last)                   state_nxt = HOLD;
          else if (!hold_full && !accept) state_nxt = WAIT;
        end
      end
      WAIT:  if (accept) state_nxt = XFER;
      HOLD:  if (cs_end) state_nxt = GAP;
      GAP:   if (cs_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Combinational outputs
  always_comb begin
    tx_rdy = 1'b0;
    case (state)
      IDLE, WAIT: tx_rdy = 1'b1;
      XFER:       tx_rdy = ~hold_full & ~cur_last;
      default:    tx_rdy = 1'b0;
    endcase
    if (rst) tx_rdy = 1'b0;
    busy = (state != IDLE) & ~rst;
  end

  // Datapath and registered SPI outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      ssn       <= 1'b1;
      sck       <= 1'b0;
      mosi      <= 1'b0;
      rx_vld    <= 1'b0;
      rx_dat    <= '0;
      half_cnt  <= '0;
      bit_cnt   <= '0;
      cs_cnt    <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      hold_dat  <= '0;
      hold_last <= 1'b0;
      hold_full <= 1'b0;
      cur_last  <= 1'b0;
    end else begin
      rx_vld <= 1'b0;
      case (state)
        IDLE: begin
          half_cnt <= '0;
          cs_cnt   <= '0;
          if (accept) begin
            tx_sr    <= tx_dat[6:0];
            mosi     <= tx_dat[7];
            cur_last <= tx_last;
            ssn      <= 1'b0;
          end
        end
        SETUP: cs_cnt <= cs_end ? '0 : cs_cnt + 1'b1;
        XFER: begin
          half_cnt <= half_end ? '0 : half_cnt + 1'b1;
          if (sck_rise) sck <= 1'b1;
          if (accept && !byte_end) begin
            hold_dat  <= tx_dat;
            hold_last <= tx_last;
            hold_full <= 1'b1;
          end
          if (sck_fall) begin
            sck     <= 1'b0;
            rx_sr   <= {rx_sr[5:0], miso};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              rx_dat <= {rx_sr, miso};
              rx_vld <= 1'b1;
              if (!cur_last) begin
                if (hold_full) begin
                  tx_sr     <= hold_dat[6:0];
                  mosi      <= hold_dat[7];
                  cur_last  <= hold_last;
                  hold_full <= 1'b0;
                end else if (accept) begin
                  tx_sr    <= tx_dat[6:0];
                  mosi     <= tx_dat[7];
                  cur_last <= tx_last;
                end
              end
            end else begin
              mosi  <= tx_sr[6];
              tx_sr <= {tx_sr[5:0], 1'b0};
            end
          end
        end
        WAIT: begin
          half_cnt <= '0;
          if (accept) begin
            tx_sr    <= tx_dat[6:0];
            mosi     <= tx_dat[7];
            cur_last <= tx_last;
          end
        end
        HOLD: begin
          if (cs_end) begin
            cs_cnt <= '0;
            ssn    <= 1'b1;
          end else begin
            cs_cnt <= cs_cnt + 1'b1;
          end
        end
        GAP: cs_cnt <= cs_end ? '0 : cs_cnt + 1'b1;
        default: cs_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed self-checking bench for spi_master
module tb_spi_master;
  localparam int CS_IDLE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       tx_vld = 1'b0, tx_last = 1'b0, tx_rdy, rx_vld, busy, ssn, sck, mosi, miso;
  logic [7:0] tx_dat = 8'h00, rx_dat;
  logic       tx_vld8 = 1'b0, tx_last8 = 1'b0, tx_rdy8, rx_vld8, busy8, ssn8, sck8, mosi8, miso8;
  logic [7:0] tx_dat8 = 8'h00, rx_dat8;

  spi_master #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(CS_IDLE)) dut (
    .clk(clk), .rst(rst), .tx_vld(tx_vld), .tx_rdy(tx_rdy), .tx_dat(tx_dat),
    .tx_last(tx_last), .rx_vld(rx_vld), .rx_dat(rx_dat), .busy(busy),
    .ssn(ssn), .sck(sck), .mosi(mosi), .miso(miso));

  spi_master #(.CLK_DIV(8), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(CS_IDLE)) dut8 (
    .clk(clk), .rst(rst), .tx_vld(tx_vld8), .tx_rdy(tx_rdy8), .tx_dat(tx_dat8),
    .tx_last(tx_last8), .rx_vld(rx_vld8), .rx_dat(rx_dat8), .busy(busy8),
    .ssn(ssn8), .sck(sck8), .mosi(mosi8), .miso(miso8));

  int checks = 0;
  int errors = 0;

  // Slave for dut: loopback or a byte table shifted on sck falling edges
  logic       loopback = 1'b1;
  logic [7:0] slv_bytes [0:3];
  logic [7:0] slv_sr = 8'h00;
  int         slv_idx = 0, slv_bit = 0;
  logic       p_ssn = 1'b1, p_sck = 1'b0;
  always @(ssn or sck) begin
    if (!ssn && p_ssn) begin
      slv_idx = 0; slv_bit = 0; slv_sr = slv_bytes[0];
    end else if (!ssn && !sck && p_sck) begin
      if (slv_bit == 7) begin
        slv_bit = 0; slv_idx = (slv_idx + 1) % 4; slv_sr = slv_bytes[slv_idx];
      end else begin
        slv_bit++; slv_sr = {slv_sr[6:0], 1'b0};
      end
    end
    p_ssn = ssn; p_sck = sck;
  end
  assign miso = loopback ? mosi : slv_sr[7];

  // Slave for dut8: returns 0x9A, captures mosi on sck rising edges
  logic [7:0] s8_tx = 8'h00, s8_rx = 8'h00;
  logic       p_ssn8 = 1'b1, p_sck8 = 1'b0;
  always @(ssn8 or sck8) begin
    if (!ssn8 && p_ssn8)              s8_tx = 8'h9A;
    else if (!ssn8 && sck8 && !p_sck8) s8_rx = {s8_rx[6:0], mosi8};
    else if (!ssn8 && !sck8 && p_sck8) s8_tx = {s8_tx[6:0], 1'b0};
    p_ssn8 = ssn8; p_sck8 = sck8;
  end
  assign miso8 = s8_tx[7];

  // Monitor on dut, sampled on the falling clk edge
  logic        mon_clr = 1'b0;
  logic        prev_sck = 1'b0;
  int          cyc = 0, rise_cnt = 0, last_rise = 0, max_rise_gap = 0, rx_cnt = 0;
  int          low_run = 0, high_run = 0, last_low = 0, last_high = 0;
  int          busy_low_run = 0, last_busy_low = 0;
  logic [31:0] mosi_sh = '0;
  logic [7:0]  rx_log [0:7];
  always @(negedge clk) begin
    cyc++;
    if (mon_clr) begin
      rise_cnt = 0; max_rise_gap = 0; rx_cnt = 0; mosi_sh = '0;
      low_run = 0; high_run = 0; last_low = 0; last_high = 0;
      busy_low_run = 0; last_busy_low = 0;
    end else begin
      if (sck && !prev_sck) begin
        if (rise_cnt > 0 && cyc - last_rise > max_rise_gap) max_rise_gap = cyc - last_rise;
        last_rise = cyc; rise_cnt++; mosi_sh = {mosi_sh[30:0], mosi};
      end
      if (rx_vld) begin
        if (rx_cnt < 8) rx_log[rx_cnt] = rx_dat;
        rx_cnt++;
      end
      if (!ssn) begin
        if (high_run != 0) last_high = high_run;
        high_run = 0; low_run++;
      end else begin
        if (low_run != 0) last_low = low_run;
        low_run = 0; high_run++;
      end
      if (!busy) busy_low_run++;
      else begin
        if (busy_low_run != 0) last_busy_low = busy_low_run;
        busy_low_run = 0;
      end
    end
    prev_sck = sck;
  end

  task automatic clear_mon();
    @(posedge clk); mon_clr = 1'b1;
    @(negedge clk); #1 mon_clr = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic l, output bit ok);
    int n = 0;
    @(negedge clk); tx_vld = 1'b1; tx_dat = d; tx_last = l;
    while (!tx_rdy && n < 2000) begin @(negedge clk); n++; end
    ok = tx_rdy;
    @(posedge clk); #1 tx_vld = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    @(negedge clk);
    while (busy && n < 5000) begin @(negedge clk); n++; end
    ok = !busy;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ssn !== 1'b1)   begin errors++; $display("FAIL reset_ssn got %b want 1", ssn); end
    checks++; if (sck !== 1'b0)   begin errors++; $display("FAIL reset_sck got %b want 0", sck); end
    checks++; if (mosi !== 1'b0)  begin errors++; $display("FAIL reset_mosi got %b want 0", mosi); end
    checks++; if (tx_rdy !== 1'b0) begin errors++; $display("FAIL reset_tx_rdy got %b want 0", tx_rdy); end
    checks++; if (rx_vld !== 1'b0) begin errors++; $display("FAIL reset_rx_vld got %b want 0", rx_vld); end
    checks++; if (rx_dat !== 8'h00) begin errors++; $display("FAIL reset_rx_dat got %h want 00", rx_dat); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (tx_rdy !== 1'b1) begin errors++; $display("FAIL idle_tx_rdy got %b want 1", tx_rdy); end
  endtask

  task automatic test_single();
    bit ok1, ok2;
    loopback = 1'b1;
    clear_mon();
    send(8'hA5, 1'b1, ok1);
    wait_idle(ok2);
    checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL single_timeout got %b%b want 11", ok1, ok2); end
    checks++; if (rise_cnt != 8) begin errors++; $display("FAIL single_rises got %0d want 8", rise_cnt); end
    checks++; if (mosi_sh[7:0] !== 8'hA5) begin errors++; $display("FAIL single_mosi got %h want a5", mosi_sh[7:0]); end
    checks++; if (rx_cnt != 1 || rx_log[0] !== 8'hA5) begin errors++; $display("FAIL single_rx got cnt %0d dat %h want 1 a5", rx_cnt, rx_log[0]); end
    checks++; if (last_low != 68) begin errors++; $display("FAIL single_ssn_low got %0d want 68", last_low); end
    checks++; if (high_run < CS_IDLE) begin errors++; $display("FAIL single_ssn_high got %0d want >=%0d", high_run, CS_IDLE); end
  endtask

  task automatic test_burst();
    bit ok1, ok2, ok3, ok4;
    loopback = 1'b0;
    slv_bytes[0] = 8'h3C; slv_bytes[1] = 8'hC3; slv_bytes[2] = 8'h00; slv_bytes[3] = 8'h00;
    clear_mon();
    send(8'h01, 1'b0, ok1);
    send(8'h80, 1'b0, ok2);
    send(8'hFF, 1'b1, ok3);
    wait_idle(ok4);
    checks++; if (!(ok1 && ok2 && ok3 && ok4)) begin errors++; $display("FAIL burst_timeout got %b%b%b%b want 1111", ok1, ok2, ok3, ok4); end
    checks++; if (rise_cnt != 24) begin errors++; $display("FAIL burst_rises got %0d want 24", rise_cnt); end
    checks++; if (max_rise_gap != 8) begin errors++; $display("FAIL burst_sck_gap got %0d want 8", max_rise_gap); end
    checks++; if (last_low != 196) begin errors++; $display("FAIL burst_ssn_low got %0d want 196", last_low); end
    checks++; if (mosi_sh[23:0] !== 24'h0180FF) begin errors++; $display("FAIL burst_mosi got %h want 0180ff", mosi_sh[23:0]); end
    checks++; if (rx_cnt != 3 || rx_log[0] !== 8'h3C || rx_log[1] !== 8'hC3 || rx_log[2] !== 8'h00)
      begin errors++; $display("FAIL burst_rx got %0d %h %h %h want 3 3c c3 00", rx_cnt, rx_log[0], rx_log[1], rx_log[2]); end
    loopback = 1'b1;
  endtask

  task automatic test_starved();
    bit ok1, ok2, ok3;
    int n = 0, bad = 0;
    loopback = 1'b1;
    clear_mon();
    send(8'h33, 1'b0, ok1);
    while (rx_cnt < 1 && n < 2000) begin @(negedge clk); n++; end
    repeat (50) begin
      @(negedge clk);
      if (sck !== 1'b0 || ssn !== 1'b0 || tx_rdy !== 1'b1 || busy !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL starved_wait got %0d bad cycles want 0", bad); end
    checks++; if (rise_cnt != 8) begin errors++; $display("FAIL starved_rises got %0d want 8", rise_cnt); end
    send(8'h55, 1'b1, ok2);
    wait_idle(ok3);
    checks++; if (!(ok1 && ok2 && ok3)) begin errors++; $display("FAIL starved_timeout got %b%b%b want 111", ok1, ok2, ok3); end
    checks++; if (rx_cnt != 2 || rx_log[0] !== 8'h33 || rx_log[1] !== 8'h55)
      begin errors++; $display("FAIL starved_rx got %0d %h %h want 2 33 55", rx_cnt, rx_log[0], rx_log[1]); end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2, ok3;
    loopback = 1'b1;
    clear_mon();
    send(8'h11, 1'b1, ok1);
    send(8'h22, 1'b1, ok2);
    wait_idle(ok3);
    checks++; if (!(ok1 && ok2 && ok3)) begin errors++; $display("FAIL b2b_timeout got %b%b%b want 111", ok1, ok2, ok3); end
    // GAP cycles plus the single IDLE cycle in which the held byte is accepted
    checks++; if (last_high != CS_IDLE + 1) begin errors++; $display("FAIL b2b_ssn_high got %0d want %0d", last_high, CS_IDLE + 1); end
    checks++; if (last_busy_low != 1) begin errors++; $display("FAIL b2b_busy_low got %0d want 1", last_busy_low); end
    checks++; if (rx_cnt != 2 || rx_log[1] !== 8'h22) begin errors++; $display("FAIL b2b_rx got %0d %h want 2 22", rx_cnt, rx_log[1]); end
  endtask

  task automatic test_reset_mid();
    bit ok1, ok2, ok3;
    int n = 0;
    loopback = 1'b1;
    clear_mon();
    send(8'hC6, 1'b1, ok1);
    while (rise_cnt < 3 && n < 2000) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (ssn !== 1'b1 || sck !== 1'b0) begin errors++; $display("FAIL midrst_outputs got ssn %b sck %b want 1 0", ssn, sck); end
    @(negedge clk); rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (rx_cnt != 0) begin errors++; $display("FAIL midrst_rx_vld got %0d pulses want 0", rx_cnt); end
    send(8'h0F, 1'b1, ok2);
    wait_idle(ok3);
    checks++; if (!(ok1 && ok2 && ok3)) begin errors++; $display("FAIL midrst_timeout got %b%b%b want 111", ok1, ok2, ok3); end
    checks++; if (rx_cnt != 1 || rx_dat !== 8'h0F) begin errors++; $display("FAIL midrst_rx got %0d %h want 1 0f", rx_cnt, rx_dat); end
  endtask

  task automatic test_integration();
    int n = 0;
    @(negedge clk); tx_vld8 = 1'b1; tx_dat8 = 8'h6E; tx_last8 = 1'b1;
    while (!tx_rdy8 && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1 tx_vld8 = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy8 && n < 5000) begin @(negedge clk); n++; end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL integ_timeout got busy %b want 0", busy8); end
    checks++; if (rx_dat8 !== 8'h9A) begin errors++; $display("FAIL integ_master_rx got %h want 9a", rx_dat8); end
    checks++; if (s8_rx !== 8'h6E) begin errors++; $display("FAIL integ_slave_rx got %h want 6e", s8_rx); end
  endtask

  initial begin
    slv_bytes[0] = 8'h00; slv_bytes[1] = 8'h00; slv_bytes[2] = 8'h00; slv_bytes[3] = 8'h00;
    test_reset();
    test_single();
    test_burst();
    test_starved();
    test_back_to_back();
    test_reset_mid();
    test_integration();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
